parallel_unloader: RTL and testbench
====================================

Name: parallel_unloader

Overview:
- Reader side of the 15-byte parallel register: captures a 120-bit bus snapshot and streams it out one byte per handshake, with a byte index.
- Uses the same byte mapping as the writer: index k ↔ bus bits [8k+7:8k].
- Sits between the parallel register's bus_out and any byte-wide consumer (UART TX, display driver, checksum unit).

Parameters:
- NUM_BYTES, 15, number of bytes in the bus; bus width = 8*NUM_BYTES.
- IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_BYTES.
- REVERSE, 0, 0 = send index 0 first, ascending; 1 = send index NUM_BYTES-1 first, descending.

Ports:
- mclk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- bus_in  input  8*NUM_BYTES  parallel word to unload; sampled only on accepted load.
- load  input  1  start request; accepted only in IDLE.
- ready  input  1  consumer can take data_out this cycle.
- data_out  output  8  current byte, registered.
- rd_dw  output  IDX_W  index of the byte on data_out, registered.
- valid  output  1  data_out/rd_dw hold a byte awaiting transfer.
- busy  output  1  high in SEND and DONE.
- done  output  1  one-cycle pulse after the last byte transfers.

Behaviour:
- Reset, asynchronous and immediate:
  - Outputs: data_out=0, rd_dw=0, valid=0, busy=0, done=0.
  - Internal state: shadow register=0, FSM=IDLE.
- Reset mid-transfer aborts the transfer with no done pulse. The first edge after reset release sees IDLE.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - load=1 at edge N → shadow <= bus_in.
  - rd_dw <= first index (0, or NUM_BYTES-1 if REVERSE).
  - data_out <= that byte of bus_in.
  - valid <= 1, busy <= 1, go to SEND.
  - Result: valid is high in cycle N+1 (1-cycle latency).
- SEND, transfer = valid & ready at a rising edge:
  - No transfer: data_out, rd_dw and valid hold stable (backpressure, unbounded).
  - Transfer, not last index: rd_dw steps ±1 per REVERSE; data_out <= shadow byte at the new index; valid stays 1. No bubbles, so ready held high gives 1 byte/cycle.
  - Transfer at last index (NUM_BYTES-1 ascending, 0 descending): valid <= 0, done <= 1, go to DONE.
- DONE, exactly one cycle: done=1, busy=1. Next edge: done <= 0, busy <= 0, go to IDLE.
- load outside IDLE (SEND or DONE) is ignored. Neither shadow nor bus_in is re-sampled, so bus_in changes during a transfer do not affect output.
- Minimum load-to-load spacing with ready=1 is NUM_BYTES+2 cycles.
- ready while valid=0 has no effect.
- Index arithmetic: never wraps. Terminates at the last index; rd_dw holds its last value in DONE/IDLE.
- data_out keeps the last byte after completion until the next load.

Test Plan:
- Reset, then bus_in bytes idx0..14 = 45,87,2e,6d,f2,da,ea,9e,3a,ef,e3,d4,ab,fe,ff; load 1 cycle; ready=1.
  - Required: valid from the next cycle for 15 consecutive cycles, with data_out/rd_dw = 45/0 … ff/14.
  - Then done pulses 1 cycle and busy falls the cycle after.
- Same bus, ready toggling 1,0,0,1,…: each byte is held stable while ready=0. Sequence unchanged, no duplicates or skips, 15 transfers total.
- REVERSE=1, same bus, ready=1: output is ff/14, fe/13, ab/12 … 45/0, then done.
- load re-asserted and bus_in changed to all 00 during SEND and during DONE: transfer completes with the original bytes, and no second transfer starts.
- Assert reset during byte idx 7 (valid=1): all outputs go to 0 immediately, no done pulse. A following load restarts cleanly from idx 0.
- load on the first cycle of IDLE after DONE: accepted, and valid rises the next cycle (back-to-back spacing of NUM_BYTES+2 cycles).

Source files
------------

// File: rtl/parallel_unloader.sv
// parallel_unloader: reader side of the parallel register. Snapshots the
// bus on an accepted load, then streams it out one byte per valid/ready
// handshake together with the byte index (index k <-> bus bits [8k+7:8k]).
module parallel_unloader #(
  parameter int NUM_BYTES = 15,
  parameter int IDX_W     = 4,
  parameter bit REVERSE   = 1'b0
) (
  input  logic                   mclk,
  input  logic                   reset,
  input  logic [8*NUM_BYTES-1:0] bus_in,
  input  logic                   load,
  input  logic                   ready,
  output logic [7:0]             data_out,
  output logic [IDX_W-1:0]       rd_dw,
  output logic                   valid,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Scan order endpoints; the index never wraps past LAST_IDX.
  localparam logic [IDX_W-1:0] FIRST_IDX = REVERSE ? IDX_W'(NUM_BYTES-1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = REVERSE ? '0 : IDX_W'(NUM_BYTES-1);

  logic [1:0]                 state;
  logic [NUM_BYTES-1:0][7:0]  shadow;
  logic [NUM_BYTES-1:0][7:0]  bus_bytes;
  logic [IDX_W-1:0]           nxt_idx;
  logic                       xfer;

  assign bus_bytes = bus_in;
  assign xfer      = valid & ready;

  // Neighbouring index in scan direction; only used when rd_dw != LAST_IDX.
  assign nxt_idx = REVERSE ? (rd_dw - IDX_W'(1)) : (rd_dw + IDX_W'(1));

  // Control FSM plus the registered byte/index outputs.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      shadow   <= '0;
      data_out <= '0;
      rd_dw    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (load) begin
            // First byte comes straight from bus_in so valid rises next cycle.
            shadow   <= bus_bytes;
            rd_dw    <= FIRST_IDX;
            data_out <= bus_bytes[FIRST_IDX];
            valid    <= 1'b1;
            busy     <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (xfer) begin
            if (rd_dw == LAST_IDX) begin
              // data_out/rd_dw keep the last byte until the next load.
              valid <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              rd_dw    <= nxt_idx;
              data_out <= shadow[nxt_idx];
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_unloader.sv
// Scoreboard bench: one ascending and one descending instance share all
// inputs. Each load pushes the expected byte stream (built from the bus
// with plain slicing) into a per-instance queue; a negedge monitor pops on
// every handshake and checks data, index, hold-under-backpressure, no
// bubbles, the done pulse and busy.
module tb_parallel_unloader;

  localparam int NB = 15;

  typedef struct packed {
    logic [7:0] b;
    logic [3:0] i;
    logic       last;
  } exp_t;

  logic            mclk = 1'b0;
  logic            reset, load, ready;
  logic [8*NB-1:0] bus_in;
  logic [7:0]      data0, data1;
  logic [3:0]      rd0, rd1;
  logic            valid0, valid1, busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int mode = 0;
  int rc = 0;

  exp_t q0[$];
  exp_t q1[$];
  bit         stall[2], cont[2], exp_dn[2], prev_dn[2];
  logic [7:0] sd[2];
  logic [3:0] si[2];

  parallel_unloader #(.NUM_BYTES(NB), .IDX_W(4), .REVERSE(1'b0)) dut (
    .mclk(mclk), .reset(reset), .bus_in(bus_in), .load(load), .ready(ready),
    .data_out(data0), .rd_dw(rd0), .valid(valid0), .busy(busy0), .done(done0));

  parallel_unloader #(.NUM_BYTES(NB), .IDX_W(4), .REVERSE(1'b1)) dut_r (
    .mclk(mclk), .reset(reset), .bus_in(bus_in), .load(load), .ready(ready),
    .data_out(data1), .rd_dw(rd1), .valid(valid1), .busy(busy1), .done(done1));

  always #5 mclk = ~mclk;

  initial forever begin
    @(posedge mclk);
    cyc++;
  end

  // ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random
  initial begin
    ready = 1'b0;
    forever begin
      @(posedge mclk);
      #1;
      rc++;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (rc % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [7:0] dat,
                     input logic [3:0] idx, input logic dn, input logic bz);
    exp_t e;
    string tag;
    tag = (d == 0) ? "asc" : "desc";
    if (reset) begin
      stall[d] = 0; cont[d] = 0; exp_dn[d] = 0; prev_dn[d] = 0;
      return;
    end
    if (stall[d]) begin
      chk(v == 1'b1, {tag, "_hold_valid"}, 32'(v), 1);
      chk(dat == sd[d], {tag, "_hold_data"}, 32'(dat), 32'(sd[d]));
      chk(idx == si[d], {tag, "_hold_idx"}, 32'(idx), 32'(si[d]));
    end
    if (cont[d]) chk(v == 1'b1, {tag, "_no_bubble"}, 32'(v), 1);
    chk(dn == exp_dn[d], {tag, "_done"}, 32'(dn), 32'(exp_dn[d]));
    if (prev_dn[d]) chk(bz == 1'b0, {tag, "_busy_fall"}, 32'(bz), 0);
    if (v) chk(bz == 1'b1, {tag, "_busy_high"}, 32'(bz), 1);
    prev_dn[d] = dn;
    exp_dn[d]  = 0;
    stall[d]   = 0;
    cont[d]    = 0;
    if (v && ready) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk(1'b0, {tag, "_extra_byte"}, 32'(idx), 32'hffff);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk(dat == e.b, {tag, "_data"}, 32'(dat), 32'(e.b));
        chk(idx == e.i, {tag, "_idx"}, 32'(idx), 32'(e.i));
        exp_dn[d] = e.last;
        cont[d]   = !e.last;
      end
    end else if (v) begin
      stall[d] = 1;
      sd[d]    = dat;
      si[d]    = idx;
    end
  endtask

  initial forever begin
    @(negedge mclk);
    mon(0, valid0, data0, rd0, done0, busy0);
    mon(1, valid1, data1, rd1, done1, busy1);
  end

  // Expected streams come directly from byte slicing of the loaded word.
  task automatic do_load(input logic [8*NB-1:0] b);
    logic [127:0] junk;
    exp_t e;
    @(posedge mclk);
    #1;
    bus_in = b;
    load   = 1'b1;
    @(posedge mclk);
    #1;
    acc_cyc = cyc;
    load    = 1'b0;
    junk    = {$urandom, $urandom, $urandom, $urandom};
    bus_in  = junk[8*NB-1:0];
    for (int k = 0; k < NB; k++) begin
      e.b = b[8*k +: 8]; e.i = 4'(k); e.last = (k == NB-1);
      q0.push_back(e);
    end
    for (int k = NB-1; k >= 0; k--) begin
      e.b = b[8*k +: 8]; e.i = 4'(k); e.last = (k == 0);
      q1.push_back(e);
    end
    @(negedge mclk);
    chk(valid0 == 1'b1, "asc_load_latency", 32'(valid0), 1);
    chk(valid1 == 1'b1, "desc_load_latency", 32'(valid1), 1);
  endtask

  // Returns at the negedge where done0 is seen high.
  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge mclk);
      if (done0) begin seen = 1; break; end
    end
    chk(seen, "done_timeout", 32'(seen), 1);
  endtask

  function automatic logic [8*NB-1:0] rand_bus();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[8*NB-1:0];
  endfunction

  logic [7:0]      fixed_bytes [NB] = '{8'h45, 8'h87, 8'h2e, 8'h6d, 8'hf2,
                                        8'hda, 8'hea, 8'h9e, 8'h3a, 8'hef,
                                        8'he3, 8'hd4, 8'hab, 8'hfe, 8'hff};
  logic [8*NB-1:0] fixed;
  int              prev_acc;
  bit              hit;

  initial begin
    for (int k = 0; k < NB; k++) fixed[8*k +: 8] = fixed_bytes[k];
    reset = 1'b1; load = 1'b0; bus_in = '0; mode = 0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk({data0, rd0, valid0, busy0, done0} == '0, "asc_reset_state",
        32'({data0, rd0, valid0, busy0, done0}), 0);
    chk({data1, rd1, valid1, busy1, done1} == '0, "desc_reset_state",
        32'({data1, rd1, valid1, busy1, done1}), 0);
    reset = 1'b0;

    // ready held high: 15 bytes back to back, then done
    mode = 0;
    do_load(fixed);
    wait_done();

    // ready 1,0,0,...: bytes held under backpressure
    mode = 1;
    do_load(fixed);
    wait_done();

    // load and zeroed bus during SEND and DONE are ignored
    mode = 0;
    do_load(fixed);
    load = 1'b1; bus_in = '0;
    wait_done();
    @(posedge mclk);
    #1;
    load = 1'b0;
    repeat (20) @(negedge mclk);
    chk(valid0 == 1'b0, "asc_no_second_xfer", 32'(valid0), 0);
    chk(q0.size() == 0, "asc_queue_drained", 32'(q0.size()), 0);
    chk(q1.size() == 0, "desc_queue_drained", 32'(q1.size()), 0);

    // back-to-back: load on first IDLE cycle after DONE
    mode = 0;
    do_load(rand_bus());
    prev_acc = acc_cyc;
    wait_done();
    do_load(rand_bus());
    chk(acc_cyc - prev_acc == NB + 2, "load_spacing",
        32'(acc_cyc - prev_acc), NB + 2);
    wait_done();

    // reset while byte 7 is presented
    mode = 2;
    do_load(fixed);
    hit = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge mclk);
      if (valid0 && rd0 == 4'd7) begin hit = 1; break; end
    end
    chk(hit, "reach_idx7", 32'(hit), 1);
    #2;
    reset = 1'b1;
    #1;
    chk({data0, rd0, valid0, busy0, done0} == '0, "asc_reset_abort",
        32'({data0, rd0, valid0, busy0, done0}), 0);
    chk({data1, rd1, valid1, busy1, done1} == '0, "desc_reset_abort",
        32'({data1, rd1, valid1, busy1, done1}), 0);
    q0.delete();
    q1.delete();
    @(posedge mclk);
    @(negedge mclk);
    chk(done0 == 1'b0, "no_done_in_reset", 32'(done0), 0);
    reset = 1'b0;
    mode = 0;
    do_load(fixed);
    wait_done();

    // randomized buses and ready patterns
    for (int n = 0; n < 8; n++) begin
      mode = int'($urandom_range(0, 2));
      do_load(rand_bus());
      wait_done();
    end
    repeat (4) @(negedge mclk);
    chk(q0.size() == 0, "asc_final_drain", 32'(q0.size()), 0);
    chk(q1.size() == 0, "desc_final_drain", 32'(q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
